// File: rtl/sha256_compression.sv
// SHA-256 compression core: consumes one expanded message word per cycle,
// runs 64 rounds on a..h, then folds the result into the chained hash H0..H7.
module sha256_compression (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_in,
  input  logic         first_block_in,
  input  logic [31:0]  message_in,
  input  logic [6:0]   round_in,
  input  logic [1:0]   fsm_state_in,
  output logic [255:0] hash_out,
  output logic         done_out,
  output logic         busy_out,
  output logic         err_out
);

  localparam int ROUNDS = 64;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [6:0]  cnt_r;
  logic [31:0] wk_r [0:7];
  logic [31:0] hv_r [0:7];
  logic        err_r;
  logic        round_ok_s;
  logic [31:0] t1_s;
  logic [31:0] t2_s;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] iv(input logic [2:0] i);
    logic [31:0] v;
    case (i)
      3'd0:    v = 32'h6a09e667;
      3'd1:    v = 32'hbb67ae85;
      3'd2:    v = 32'h3c6ef372;
      3'd3:    v = 32'ha54ff53a;
      3'd4:    v = 32'h510e527f;
      3'd5:    v = 32'h9b05688c;
      3'd6:    v = 32'h1f83d9ab;
      3'd7:    v = 32'h5be0cd19;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Round-word qualification and the two round temporaries
  always_comb begin
    round_ok_s = (fsm_state_in != 2'b00) && (round_in == cnt_r);
    t1_s = wk_r[7] + big_sigma1(wk_r[4]) + ((wk_r[4] & wk_r[5]) ^ (~wk_r[4] & wk_r[6]))
         + k_const(cnt_r[5:0]) + message_in;
    t2_s = big_sigma0(wk_r[0]) + ((wk_r[0] & wk_r[1]) ^ (wk_r[0] & wk_r[2]) ^ (wk_r[1] & wk_r[2]));
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a bad word in ROUNDS abandons the block
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) state_s = ST_ROUNDS;
        else          state_s = ST_IDLE;
      end
      ST_ROUNDS: begin
        if (!round_ok_s)               state_s = ST_IDLE;
        else if (cnt_r == LAST_ROUND)  state_s = ST_UPDATE;
        else                           state_s = ST_ROUNDS;
      end
      ST_UPDATE: state_s = ST_DONE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Working registers, chained hash, round counter and sticky error
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= 7'd0;
      err_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wk_r[i] <= 32'h0;
        hv_r[i] <= iv(3'(i));
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            err_r <= 1'b0;
            cnt_r <= 7'd0;
            for (int i = 0; i < 8; i++) begin
              if (first_block_in) begin
                hv_r[i] <= iv(3'(i));
                wk_r[i] <= iv(3'(i));
              end else begin
                wk_r[i] <= hv_r[i];
              end
            end
          end
        end
        ST_ROUNDS: begin
          if (round_ok_s) begin
            wk_r[7] <= wk_r[6];
            wk_r[6] <= wk_r[5];
            wk_r[5] <= wk_r[4];
            wk_r[4] <= wk_r[3] + t1_s;
            wk_r[3] <= wk_r[2];
            wk_r[2] <= wk_r[1];
            wk_r[1] <= wk_r[0];
            wk_r[0] <= t1_s + t2_s;
            cnt_r   <= cnt_r + 7'd1;
          end else begin
            err_r <= 1'b1;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            hv_r[i] <= hv_r[i] + wk_r[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign hash_out = {hv_r[0], hv_r[1], hv_r[2], hv_r[3], hv_r[4], hv_r[5], hv_r[6], hv_r[7]};
  assign done_out = (state_r == ST_DONE);
  assign busy_out = (state_r != ST_IDLE);
  assign err_out  = err_r;

endmodule

// File: doc/sha256_compression.md
Name: sha256_compression

Overview:
- Consumer end of the SHA-256 message-word stream produced by the message expansion block.
- Each cycle it takes one expanded word W[t] plus the round index, adds the internal K[t] constant, and runs one compression round on the working registers a..h.
- After 64 rounds it folds a..h into the running hash H0..H7 and pulses done.
- Supports multi-block messages by chaining H across blocks.

Parameters:
- ROUNDS, 64, number of compression rounds per block; fixed by SHA-256, not to be overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- start_in  input  1  block start; driven in the same cycle as the expansion block's start.
- first_block_in  input  1  sampled with start_in; 1 = initialise H from the IV, 0 = chain from the current H.
- message_in  input  32  expanded word W[t] from the expansion block.
- round_in  input  7  round index t accompanying message_in.
- fsm_state_in  input  2  expansion FSM state; any non-zero value means message_in is valid.
- hash_out  output  256  {H0..H7}, H0 in bits [255:224]; always reflects the H registers.
- done_out  output  1  one-cycle pulse when hash_out holds the updated hash.
- busy_out  output  1  high in any state other than IDLE.
- err_out  output  1  sticky protocol error; cleared on the next accepted start_in.

Behaviour:
- Reset (asynchronous, RST=0):
  - state = IDLE; round counter = 0; a..h = 0.
  - H0..H7 = IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - done_out = 0, busy_out = 0, err_out = 0.
  - Reset mid-block aborts with no partial H update.
- FSM states: IDLE, ROUNDS, UPDATE, DONE.
- IDLE:
  - On start_in=1 at edge E0: err_out <= 0; round counter <= 0; go to ROUNDS.
  - If first_block_in=1, H <= IV and a..h <= IV.
  - If first_block_in=0, a..h <= H and H is unchanged.
- Start in other states: start_in outside IDLE is ignored.
- ROUNDS, at each edge E1..E64:
  - Requires fsm_state_in != 0 and round_in == round counter.
  - T1 = h + SIGMA1(e) + Ch(e,f,g) + K[t] + W; T2 = SIGMA0(a) + Maj(a,b,c).
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - All additions are modulo 2^32; carries are discarded.
  - SIGMA1 = ROTR6^ROTR11^ROTR25; SIGMA0 = ROTR2^ROTR13^ROTR22; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - K[0..63] is an internal 64-entry constant table indexed by the round counter.
  - Round counter increments by 1; after the round-63 update (E64) go to UPDATE.
- Protocol violation in ROUNDS (fsm_state_in == 0, or round_in != counter):
  - No round update; err_out <= 1; go to IDLE.
  - H unchanged; done_out never pulses for that block.
- UPDATE (edge E65): Hi <= Hi + working reg i (mod 2^32) for i=0..7; go to DONE.
- DONE: done_out=1 for exactly this one cycle; at E66 go to IDLE.
- Latency: start accepted at E0, done_out high in the cycle after E65, and a new start is accepted in that DONE cycle's following IDLE cycle. This lines up with the expansion block returning to IDLE after E64.
- Outputs: done_out and busy_out are decoded from registered state, so they are glitch-free.

Test Plan:
- "abc" single padded block, first_block_in=1 -> done_out pulses exactly 66 cycles after start; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-string padded block -> hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second start with first_block_in=0 -> after the second done_out, hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Force fsm_state_in=0 at round 20 -> err_out=1 next cycle, busy_out=0, no done_out, hash_out unchanged (IV); the next start clears err_out.
- Assert RST=0 at round 30 -> immediately hash_out = IV, busy_out=0, done_out=0; a fresh "abc" run afterwards yields the correct digest.
- Pulse start_in at round 10 while busy -> ignored; the digest is unchanged and done_out still pulses at cycle 66.
